// File: rtl/attn_job_sequencer_pkg.sv
// Shared definitions for the attention job sequencer.
// Holds the default SRAM address/data widths (kept equal to the common SRAM
// address/data ranges) and the sequencer state encoding.
package attn_job_sequencer_pkg;

  localparam int SEQ_ADDR_W = 16;
  localparam int SEQ_DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_DRAIN     = 3'd4,
    S_FINISH    = 3'd5
  } seq_state_t;

endpackage

// File: rtl/attn_job_sequencer_if.sv
// Bus bundle between the sequencer and its surroundings.
//   dut_valid/dut_ready              : job launch handshake with the accelerator
//   result_read_address/_data        : result SRAM read port (data 1 cycle late)
//   rd_data/rd_valid/rd_last/rd_ready: streamed result words to the consumer
// master = sequencer side, slave = accelerator/SRAM/consumer side.
interface attn_job_sequencer_if
  import attn_job_sequencer_pkg::*;
#(
  parameter int ADDR_W = SEQ_ADDR_W,
  parameter int DATA_W = SEQ_DATA_W
) ();

  logic              dut_valid;
  logic              dut_ready;
  logic [ADDR_W-1:0] result_read_address;
  logic [DATA_W-1:0] result_read_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_last;
  logic              rd_ready;

  modport master (
    output dut_valid, result_read_address, rd_data, rd_valid, rd_last,
    input  dut_ready, result_read_data, rd_ready
  );

  modport slave (
    input  dut_valid, result_read_address, rd_data, rd_valid, rd_last,
    output dut_ready, result_read_data, rd_ready
  );

endinterface

// File: rtl/attn_job_sequencer_seq_fifo2.sv
// seq_fifo2: two-entry FIFO holding {last, data} result words.
// Ports: clk, reset_n (async active-low), clr (sync flush), push/din,
//        pop/dout (head word, stable until popped), count, empty.
// Callers never push when full or pop when empty.
module seq_fifo2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wptr;
  logic         rptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      count  <= 2'd0;
    end else if (clr) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr] <= din;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout  = mem[rptr];
  assign empty = (count == 2'd0);

endmodule

// File: rtl/attn_job_sequencer.sv
// attn_job_sequencer: launches one job on the attention accelerator, waits
// for it to finish, then reads result words RESULT_BASE..RESULT_BASE+N-1
// (N = rows * b_cols) and streams them out with valid/ready.
// Ports: clk, reset_n, start, cfg_rows, cfg_b_cols, busy, done, err_timeout,
//        bus (master modport: accelerator handshake, SRAM read, stream out).
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | waiting for start
// S_LAUNCH    | range check, then pulse dut_valid once dut_ready is high
// S_WAIT_ACK  | waiting for the accelerator to drop dut_ready
// S_WAIT_DONE | waiting for dut_ready to return (job complete)
// S_DRAIN     | reading result SRAM and streaming words out
// S_FINISH    | one-cycle done pulse
module attn_job_sequencer
  import attn_job_sequencer_pkg::*;
#(
  parameter int ADDR_W         = SEQ_ADDR_W,
  parameter int DATA_W         = SEQ_DATA_W,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int RESULT_BASE    = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [15:0]          cfg_rows,
  input  logic [15:0]          cfg_b_cols,
  output logic                 busy,
  output logic                 done,
  output logic                 err_timeout,
  attn_job_sequencer_if.master bus
);

  seq_state_t state, state_nx;

  logic [15:0]   rows_q, cols_q;
  logic [31:0]   n_words, idx, tmr;
  logic [32:0]   addr_lim;
  logic          range_err, tmr_tc;
  logic          accept, set_err, issue, launch;
  logic          inflight, inflight_last;
  logic          pop, fifo_empty;
  logic [1:0]    fifo_cnt, slots;
  logic [DATA_W:0] fifo_dout;

  assign n_words   = 32'(rows_q) * 32'(cols_q);
  assign addr_lim  = (33'd1 << ADDR_W) - 33'(RESULT_BASE);
  assign range_err = ({1'b0, n_words} > addr_lim);
  assign tmr_tc    = (tmr == 32'd0);

  // A word popped this cycle frees its slot in time for a read issued now,
  // which is what lets the drain sustain one word per cycle.
  assign pop   = !fifo_empty && bus.rd_ready;
  assign slots = fifo_cnt + {1'b0, inflight} - {1'b0, pop};

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    set_err  = 1'b0;
    issue    = 1'b0;
    launch   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (range_err) begin
          set_err  = 1'b1;
          state_nx = S_IDLE;
        end else if (bus.dut_ready) begin
          launch   = 1'b1;
          state_nx = S_WAIT_ACK;
        end else if (tmr_tc) begin
          set_err  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_WAIT_ACK: begin
        if (!bus.dut_ready) begin
          state_nx = S_WAIT_DONE;
        end else if (tmr_tc) begin
          set_err  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (bus.dut_ready) begin
          state_nx = (n_words == 32'd0) ? S_FINISH : S_DRAIN;
        end else if (tmr_tc) begin
          set_err  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_DRAIN: begin
        issue = (idx < n_words) && (slots < 2'd2);
        if (pop && fifo_dout[DATA_W]) state_nx = S_FINISH;
      end
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      rows_q        <= 16'd0;
      cols_q        <= 16'd0;
      idx           <= 32'd0;
      tmr           <= 32'd0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      state <= state_nx;
      // Timeout down-counter reloads on every state change; terminal count
      // on the TIMEOUT_CYCLES-th cycle spent in the same state.
      if (state_nx != state) tmr <= 32'(TIMEOUT_CYCLES - 1);
      else if (!tmr_tc)      tmr <= tmr - 32'd1;
      if (accept) begin
        rows_q      <= cfg_rows;
        cols_q      <= cfg_b_cols;
        idx         <= 32'd0;
        err_timeout <= 1'b0;
      end
      if (set_err) err_timeout <= 1'b1;
      if (issue)   idx <= idx + 32'd1;
      inflight      <= issue;
      inflight_last <= issue && (idx == n_words - 32'd1);
    end
  end

  seq_fifo2 #(.W(DATA_W + 1)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (accept),
    .push    (inflight),
    .din     ({inflight_last, bus.result_read_data}),
    .pop     (pop),
    .dout    (fifo_dout),
    .count   (fifo_cnt),
    .empty   (fifo_empty)
  );

  assign bus.dut_valid           = launch;
  assign bus.result_read_address = ADDR_W'(RESULT_BASE) + idx[ADDR_W-1:0];
  assign bus.rd_valid            = !fifo_empty;
  assign bus.rd_data             = fifo_dout[DATA_W-1:0];
  assign bus.rd_last             = fifo_dout[DATA_W] && !fifo_empty;
  assign busy                    = (state != S_IDLE) && (state != S_FINISH);
  assign done                    = (state == S_FINISH);

endmodule

// File: tb/tb_attn_job_sequencer.sv
module tb_attn_job_sequencer;

  localparam int TO = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_rows = 16'd0;
  logic [15:0] cfg_b_cols = 16'd0;
  logic        busy, done, err_timeout;

  attn_job_sequencer_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  attn_job_sequencer #(
    .ADDR_W(16), .DATA_W(32), .TIMEOUT_CYCLES(TO), .RESULT_BASE(0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .cfg_rows    (cfg_rows),
    .cfg_b_cols  (cfg_b_cols),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference: expected stream as {last, data}, filled from the SRAM image
  logic [31:0] mem [0:1023];
  logic [32:0] exp_q [$];
  int          cyc = 0;
  int          n_valid = 0, n_done = 0, words = 0;
  int          accel_delay = 5;
  bit          accel_hang = 0;
  int          rr_mode = 0;
  int          last_cyc = -1, prev_hs_cyc = -1;
  bit          job_word0 = 1;

  always @(posedge clk) cyc <= cyc + 1;

  // result SRAM: data for the address seen this cycle appears next cycle
  initial begin
    logic [15:0] a;
    bus.result_read_data = '0;
    forever begin
      @(negedge clk);
      a = bus.result_read_address;
      @(posedge clk);
      #1 bus.result_read_data = mem[a[9:0]];
    end
  end

  // accelerator: drop ready the cycle after launch, raise it after a delay
  initial begin
    bus.dut_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (reset_n && bus.dut_valid) begin
        n_valid++;
        @(posedge clk);
        #1 bus.dut_ready = 1'b0;
        if (!accel_hang) begin
          repeat (accel_delay) @(posedge clk);
          #1 bus.dut_ready = 1'b1;
        end
      end
    end
  end

  // consumer ready patterns: 0 = always, 1 = 1,0,0 repeating, 2 = random
  initial begin
    int ph = 0;
    bus.rd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       bus.rd_ready = 1'b1;
        1:       bus.rd_ready = (ph % 3 == 0);
        default: bus.rd_ready = 1'($urandom_range(0, 1));
      endcase
      ph++;
    end
  end

  // stream monitor / scoreboard
  initial begin
    bit          stall = 0;
    logic [31:0] s_data;
    logic        s_last;
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stall = 0;
        continue;
      end
      if (stall) begin
        check_eq("stall_valid", bus.rd_valid, 1);
        check_eq("stall_data", bus.rd_data, s_data);
        check_eq("stall_last", bus.rd_last, s_last);
      end
      if (bus.rd_valid && bus.rd_ready) begin
        check_eq("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("rd_data", bus.rd_data, e[31:0]);
          check_eq("rd_last", bus.rd_last, e[32]);
        end
        if (rr_mode == 0 && !job_word0) check_eq("back_to_back", cyc - prev_hs_cyc, 1);
        job_word0   = 0;
        prev_hs_cyc = cyc;
        if (bus.rd_last) last_cyc = cyc;
        words++;
      end
      stall  = bus.rd_valid && !bus.rd_ready;
      s_data = bus.rd_data;
      s_last = bus.rd_last;
      if (done) begin
        n_done++;
        if (last_cyc >= 0) check_eq("done_after_last", cyc - last_cyc, 1);
      end
    end
  end

  task automatic pulse_start(input int rows, input int cols);
    @(negedge clk);
    cfg_rows   = 16'(rows);
    cfg_b_cols = 16'(cols);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic load_job(input int rows, input int cols);
    int n = rows * cols;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      mem[i] = $urandom;
      exp_q.push_back({1'(i == n - 1), mem[i]});
    end
    last_cyc  = -1;
    job_word0 = 1;
  endtask

  task automatic run_job(input string tag, input int rows, input int cols,
                         input int mode, input int delay, input bit extra_start);
    int  v0, d0, since;
    bit  seen;
    load_job(rows, cols);
    rr_mode     = mode;
    accel_delay = delay;
    v0 = n_valid;
    d0 = n_done;
    pulse_start(rows, cols);
    check_eq({tag, "_busy"}, busy, 1);
    check_eq({tag, "_err_clr"}, err_timeout, 0);
    seen  = 0;
    since = 0;
    for (int g = 0; g < 3000 && !seen; g++) begin
      @(negedge clk);
      if (start) start = 1'b0;
      if (extra_start && n_valid > v0) begin
        since++;
        if (since == 5) begin
          cfg_rows = 16'd7;
          start    = 1'b1;
        end
      end
      if (done) seen = 1;
    end
    start = 1'b0;
    #1;
    check_eq({tag, "_done_seen"}, seen, 1);
    check_eq({tag, "_busy_end"}, busy, 0);
    check_eq({tag, "_words_left"}, exp_q.size(), 0);
    repeat (30) @(negedge clk);
    #1;
    check_eq({tag, "_launches"}, n_valid - v0, 1);
    check_eq({tag, "_dones"}, n_done - d0, 1);
    check_eq({tag, "_err"}, err_timeout, 0);
  endtask

  initial begin
    int v0, d0, k, w0;
    bit hit;

    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err_timeout, 0);
    check_eq("rst_dut_valid", bus.dut_valid, 0);
    check_eq("rst_rd_valid", bus.rd_valid, 0);
    check_eq("rst_rd_last", bus.rd_last, 0);
    check_eq("rst_addr", bus.result_read_address, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_job("basic", 2, 2, 0, 20, 0);
    run_job("bp", 2, 3, 1, 8, 0);
    run_job("zero", 0, 5, 0, 6, 0);
    run_job("busy_start", 3, 2, 0, 15, 1);

    // range error: N above the SRAM address space
    v0 = n_valid;
    d0 = n_done;
    pulse_start(257, 256);
    repeat (3) @(negedge clk);
    check_eq("range_err", err_timeout, 1);
    check_eq("range_busy", busy, 0);
    check_eq("range_no_launch", n_valid - v0, 0);
    check_eq("range_no_done", n_done - d0, 0);

    // timeout: accelerator never completes
    accel_hang = 1;
    load_job(1, 1);
    v0 = n_valid;
    d0 = n_done;
    pulse_start(1, 1);
    hit = 0;
    for (int g = 0; g < 20 && !hit; g++) begin
      if (bus.dut_valid) hit = 1;
      else @(negedge clk);
    end
    check_eq("to_launch", hit, 1);
    hit = 0;
    k   = 0;
    for (int g = 0; g < 4 * TO && !hit; g++) begin
      @(negedge clk);
      k++;
      if (err_timeout) hit = 1;
    end
    check_eq("to_err", hit, 1);
    check_eq("to_cycles", k, TO + 2);
    check_eq("to_busy", busy, 0);
    repeat (5) @(negedge clk);
    check_eq("to_no_done", n_done - d0, 0);
    accel_hang    = 0;
    bus.dut_ready = 1'b1;
    repeat (2) @(negedge clk);
    run_job("after_to", 2, 1, 0, 4, 0);

    // reset in the middle of draining
    load_job(2, 2);
    rr_mode     = 0;
    accel_delay = 5;
    w0 = words;
    pulse_start(2, 2);
    for (int g = 0; g < 200 && words - w0 < 2; g++) @(negedge clk);
    check_eq("mid_words", words - w0, 2);
    reset_n = 1'b0;
    #1;
    check_eq("mid_busy", busy, 0);
    check_eq("mid_rd_valid", bus.rd_valid, 0);
    check_eq("mid_rd_last", bus.rd_last, 0);
    check_eq("mid_rd_data", bus.rd_data, 0);
    check_eq("mid_dut_valid", bus.dut_valid, 0);
    check_eq("mid_addr", bus.result_read_address, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    run_job("post_rst", 2, 2, 0, 7, 0);

    for (int j = 0; j < 8; j++) begin
      run_job("rand", $urandom_range(0, 5), $urandom_range(0, 6),
              $urandom_range(0, 2), $urandom_range(1, 25), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
